// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: one full-subtractor cell, LSB first over WIDTH cycles,
// with a start/busy/done handshake and unsigned borrow / signed overflow flags.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] sa, sb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic             d, br, last;

  // Full-subtractor cell fed from the operand LSBs and the borrow flop.
  assign d    = sa[0] ^ sb[0] ^ brw;
  assign br   = (~(sa[0] ^ sb[0]) & brw) | (~sa[0] & sb[0]);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs come straight from flops, so start never reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (nxt != IDLE);
      done <= (nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      sa    <= a;
      sb    <= b;
      brw   <= 1'b0;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      diff <= {d, diff[WIDTH-1:1]};
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      brw  <= br;
      cnt  <= cnt + CW'(1);
      // Only the value written on the final edge matters: that d is the result MSB.
      ovf  <= (a_msb != b_msb) && (d != a_msb);
      if (last) bout <= br;
    end
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller computing diff = a - b over WIDTH clock cycles, LSB first.
- Uses a single 1-bit full-subtractor cell: d = a^b^bin, br = (~(a^b)&bin)|(~a&b).
- Owns operand shift registers, the borrow flip-flop, the bit counter and the start/busy/done handshake.
- Sits between a requesting sequencer and the result register file, trading area for latency.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  a - b modulo 2^WIDTH
bout  output  1  final borrow (1 when a < b unsigned)
ovf  output  1  signed overflow of a - b

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; shift registers, borrow flip-flop and counter cleared. Reset mid-RUN aborts; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0, capture a and b into shift regs, borrow<=0, count<=0, latch a[WIDTH-1] and b[WIDTH-1] for ovf, go to RUN. diff, bout and ovf hold their previous values until the first RUN edge.
- RUN, each edge:
  - Cell inputs are shift-reg LSBs plus the borrow flip-flop.
  - Cell d is shifted into diff from the MSB side (diff <= {d, diff[WIDTH-1:1]}).
  - Operand regs shift right; borrow <= br; count++.
  - When count reaches WIDTH-1 on that edge's processing (i.e., the WIDTH-th RUN edge), go to DONE and load bout <= br.
  - ovf <= (a_msb != b_msb) && (d != a_msb), using that edge's d as the result MSB.
- DONE: lasts exactly one cycle. done=1 and busy=1; next edge returns to IDLE.
- Latency: start accepted at E0; RUN edges E1..E_WIDTH; done high in the cycle after E_WIDTH. Total is WIDTH+1 cycles from the start edge to the done cycle.
- After DONE, diff, bout and ovf hold stable until the next accepted start's first RUN edge.
- start while busy (RUN or DONE) is ignored, with no queuing. Issuing a new start in the cycle after done gives back-to-back operation, i.e. one result per WIDTH+2 cycles.
- a and b may change freely after capture without affecting the result.
- Arithmetic is unsigned modulo 2^WIDTH for diff; bout is the unsigned borrow. ovf follows two's-complement interpretation.
- done and busy are registered outputs with no combinational path from start.

Test Plan:
- WIDTH=8, a=0x25, b=0x13, start 1 cycle -> busy for 9 cycles, done pulse exactly 9 cycles after the start edge; diff=0x12, bout=0, ovf=0.
- a=0x13, b=0x25 -> diff=0xEE, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x00, b=0x00 -> diff=0x00, bout=0, ovf=0. Then a=0x00, b=0xFF -> diff=0x01, bout=1.
- Start a=0x50, b=0x10. At RUN cycle 3, pulse start with a=0xFF, b=0xFF and change a/b inputs -> second request ignored; result diff=0x40, exactly one done pulse.
- Start a=0xAA, b=0x55. Assert rst asynchronously mid-RUN (between clock edges) -> outputs 0 immediately, no done. After release, start a=0x0F, b=0x01 -> diff=0x0E with normal latency.
- Back-to-back: start asserted in the cycle after each done for 4 random operand pairs -> each result matches the modulo-256 reference model; done spacing is 10 cycles.
